ixu_mc_sequencer: RTL and testbench

Controller for the IXU multi-cycle execution port. Accepts ops issued on the scheduler's multi-cycle output, sequences a pipelined multiplier and a shared iterative divider, and merges both completion streams onto one writeback/wakeup port. Generates the busy signal the scheduler uses to hold multi-cycle issue while the divider is occupied.

---
 rtl/ixu_mc_sequencer_if.sv | 27 ++
 rtl/ixu_mc_sequencer.sv | 141 ++++++++++++++
 tb/tb_ixu_mc_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ixu_mc_sequencer_if.sv
// Multi-cycle issue, execution-strobe and writeback/wakeup bundle of the IXU multi-cycle port.
// The slave side is the sequencer; the master side is the scheduler/testbench.
interface ixu_mc_sequencer_if;
   logic       mc_vld_i;
   logic [5:0] mc_rob_i;
   logic [5:0] mc_prd_i;
   logic       mc_div_i;
   logic       mc_busy_o;
   logic       mul_start_o;
   logic       div_start_o;
   logic       wb_vld_o;
   logic [5:0] wb_rob_o;
   logic [5:0] wb_prd_o;
   logic       wb_sel_o;

   modport slave (
      input  mc_vld_i, mc_rob_i, mc_prd_i, mc_div_i,
      output mc_busy_o, mul_start_o, div_start_o,
      output wb_vld_o, wb_rob_o, wb_prd_o, wb_sel_o
   );

   modport master (
      output mc_vld_i, mc_rob_i, mc_prd_i, mc_div_i,
      input  mc_busy_o, mul_start_o, div_start_o,
      input  wb_vld_o, wb_rob_o, wb_prd_o, wb_sel_o
   );
endinterface

// File: rtl/ixu_mc_sequencer.sv
// Sequences a pipelined multiplier and a shared iterative divider behind one multi-cycle issue
// port and merges both completion streams onto a single registered writeback/wakeup port.
module ixu_mc_sequencer #(
   parameter int unsigned MUL_LAT    = 3,
   parameter int unsigned DIV_CYCLES = 16
) (
   input logic                core_clock_i,
   input logic                core_reset_i,
   input logic                core_flush_i,
   ixu_mc_sequencer_if.slave  mc
);

   localparam int unsigned CntW = $clog2(DIV_CYCLES);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e            r_state;
   state_e            w_state_d;
   logic [CntW-1:0]   r_cnt;
   logic [CntW-1:0]   w_cnt_d;
   logic [11:0]       r_div_tag;
   logic              r_wb_vld;
   logic [5:0]        r_wb_rob;
   logic [5:0]        r_wb_prd;
   logic              r_wb_sel;

   logic [11:0]       w_issue_tag;
   logic              w_mul_acc;
   logic              w_div_acc;
   logic              w_claim_vld;
   logic [11:0]       w_claim_tag;
   logic              w_grant;

   assign w_issue_tag = {mc.mc_rob_i, mc.mc_prd_i};
   assign w_mul_acc   = mc.mc_vld_i & ~mc.mc_div_i & ~core_flush_i;
   // A divide arriving while the divider is occupied is dropped without a strobe.
   assign w_div_acc   = mc.mc_vld_i & mc.mc_div_i & ~core_flush_i & (r_state == StIdle);

   // Multiplier token pipe; its last stage is the token that loads wb at the next edge.
   if (MUL_LAT == 1) begin : g_lat1
      assign w_claim_vld = w_mul_acc;
      assign w_claim_tag = w_issue_tag;
   end else begin : g_pipe
      logic [MUL_LAT-2:0]        r_pipe_vld;
      logic [MUL_LAT-2:0][11:0]  r_pipe_tag;

      always_ff @(posedge core_clock_i or posedge core_reset_i) begin
         if (core_reset_i) begin
            r_pipe_vld <= '0;
            r_pipe_tag <= '0;
         end else begin
            r_pipe_vld[0] <= w_mul_acc;
            r_pipe_tag[0] <= w_issue_tag;
            for (int i = 1; i < int'(MUL_LAT) - 1; i++) begin
               r_pipe_vld[i] <= r_pipe_vld[i-1] & ~core_flush_i;
               r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
         end
      end

      assign w_claim_vld = r_pipe_vld[MUL_LAT-2];
      assign w_claim_tag = r_pipe_tag[MUL_LAT-2];
   end

   // Multiplier has fixed priority; the divider waits in DONE until the port is free.
   assign w_grant = (r_state == StDone) & ~w_claim_vld & ~core_flush_i;

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      if (core_flush_i) begin
         w_state_d = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_div_acc) begin
                  w_state_d = StRun;
                  w_cnt_d   = CntW'(DIV_CYCLES - 1);
               end
            end
            StRun: begin
               w_cnt_d = r_cnt - CntW'(1);
               if (r_cnt == CntW'(1)) begin
                  w_state_d = StDone;
               end
            end
            StDone: begin
               if (w_grant) begin
                  w_state_d = StIdle;
               end
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_div_tag <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         if (w_div_acc) begin
            r_div_tag <= w_issue_tag;
         end
      end
   end

   always_ff @(posedge core_clock_i or posedge core_reset_i) begin
      if (core_reset_i) begin
         r_wb_vld <= 1'b0;
         r_wb_rob <= '0;
         r_wb_prd <= '0;
         r_wb_sel <= 1'b0;
      end else if (core_flush_i) begin
         r_wb_vld <= 1'b0;
      end else if (w_claim_vld) begin
         r_wb_vld <= 1'b1;
         {r_wb_rob, r_wb_prd} <= w_claim_tag;
         r_wb_sel <= 1'b0;
      end else if (w_grant) begin
         r_wb_vld <= 1'b1;
         {r_wb_rob, r_wb_prd} <= r_div_tag;
         r_wb_sel <= 1'b1;
      end else begin
         r_wb_vld <= 1'b0;
      end
   end

   assign mc.mc_busy_o   = (r_state == StRun) | ((r_state == StDone) & ~w_grant)
                         | (mc.mc_vld_i & mc.mc_div_i);
   assign mc.mul_start_o = w_mul_acc;
   assign mc.div_start_o = w_div_acc;
   assign mc.wb_vld_o    = r_wb_vld;
   assign mc.wb_rob_o    = r_wb_rob;
   assign mc.wb_prd_o    = r_wb_prd;
   assign mc.wb_sel_o    = r_wb_sel;

endmodule

// File: tb/tb_ixu_mc_sequencer.sv
// Directed and randomized bench for ixu_mc_sequencer against a cycle-scheduled reference model:
// muls land at a fixed future cycle, the divide lands at the first free cycle after it is ready.
module tb_ixu_mc_sequencer;
   localparam int unsigned MUL_LAT    = 3;
   localparam int unsigned DIV_CYCLES = 16;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   always #5 clk = ~clk;

   ixu_mc_sequencer_if u_if ();

   ixu_mc_sequencer #(
      .MUL_LAT    (MUL_LAT),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_dut (
      .core_clock_i (clk),
      .core_reset_i (rst),
      .core_flush_i (flush),
      .mc           (u_if)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model: writeback cycle -> {rob, prd} of the multiply landing there.
   logic [11:0] mul_at [int];
   bit          div_pend;
   int          div_ready;
   logic [11:0] div_tag;
   logic [5:0]  last_rob;
   logic [5:0]  last_prd;
   logic        last_sel;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      mul_at.delete();
      div_pend = 1'b0;
      last_rob = '0;
      last_prd = '0;
      last_sel = 1'b0;
   endtask

   task automatic step(input logic vld, input logic div, input logic [5:0] rob,
                       input logic [5:0] prd, input logic fl);
      logic        e_vld;
      logic        claim;
      logic        grant;
      logic        mul_acc;
      logic        div_acc;
      logic [11:0] tag;
      @(posedge clk);
      #1;
      cyc++;
      u_if.mc_vld_i = vld;
      u_if.mc_div_i = div;
      u_if.mc_rob_i = rob;
      u_if.mc_prd_i = prd;
      flush         = fl;
      @(negedge clk);
      e_vld = 1'b0;
      if (mul_at.exists(cyc)) begin
         tag = mul_at[cyc];
         e_vld = 1'b1;
         last_rob = tag[11:6];
         last_prd = tag[5:0];
         last_sel = 1'b0;
         mul_at.delete(cyc);
      end else if (div_pend && cyc >= div_ready) begin
         e_vld = 1'b1;
         last_rob = div_tag[11:6];
         last_prd = div_tag[5:0];
         last_sel = 1'b1;
         div_pend = 1'b0;
      end
      chk("wb_vld", u_if.wb_vld_o, e_vld);
      chk("wb_rob", u_if.wb_rob_o, last_rob);
      chk("wb_prd", u_if.wb_prd_o, last_prd);
      chk("wb_sel", u_if.wb_sel_o, last_sel);
      mul_acc = vld && !div && !fl;
      div_acc = vld && div && !fl && !div_pend;
      claim   = mul_at.exists(cyc + 1) || (MUL_LAT == 1 && mul_acc);
      grant   = div_pend && (cyc + 1 >= div_ready) && !claim && !fl;
      chk("mc_busy", u_if.mc_busy_o, (div_pend && !grant) || (vld && div));
      chk("mul_start", u_if.mul_start_o, mul_acc);
      chk("div_start", u_if.div_start_o, div_acc);
      if (fl) begin
         mul_at.delete();
         div_pend = 1'b0;
      end else begin
         if (mul_acc) mul_at[cyc + int'(MUL_LAT)] = {rob, prd};
         if (div_acc) begin
            div_pend  = 1'b1;
            div_ready = cyc + int'(DIV_CYCLES) + 1;
            div_tag   = {rob, prd};
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 6'd0, 1'b0);
   endtask

   task automatic mul(input logic [5:0] rob, input logic [5:0] prd);
      step(1'b1, 1'b0, rob, prd, 1'b0);
   endtask

   task automatic dvd(input logic [5:0] rob, input logic [5:0] prd);
      step(1'b1, 1'b1, rob, prd, 1'b0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear without a clock.
   task automatic async_reset();
      u_if.mc_vld_i = 1'b0;
      u_if.mc_div_i = 1'b0;
      flush         = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_clear();
      chk("rst_wb_vld", u_if.wb_vld_o, 1'b0);
      chk("rst_busy", u_if.mc_busy_o, 1'b0);
      chk("rst_wb_rob", u_if.wb_rob_o, 6'd0);
      chk("rst_wb_prd", u_if.wb_prd_o, 6'd0);
      chk("rst_wb_sel", u_if.wb_sel_o, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic v;
      logic d;
      logic f;
      rst           = 1'b0;
      flush         = 1'b0;
      u_if.mc_vld_i = 1'b0;
      u_if.mc_div_i = 1'b0;
      u_if.mc_rob_i = '0;
      u_if.mc_prd_i = '0;
      model_clear();
      async_reset();

      // Single multiply, then back-to-back multiplies.
      mul(6'd5, 6'd12);
      idle(5);
      mul(6'd1, 6'd1);
      mul(6'd2, 6'd2);
      mul(6'd3, 6'd3);
      idle(5);

      // Uncontested divide with a mul landing just before its writeback.
      dvd(6'd9, 6'd40);
      idle(12);
      mul(6'd5, 6'd12);
      idle(8);

      // Mul landing in the divider's first DONE cycle pushes the divide back one cycle.
      dvd(6'd10, 6'd41);
      idle(13);
      mul(6'd6, 6'd13);
      idle(8);

      // Flush while dividing with mul tokens in flight, new divide right after.
      dvd(6'd11, 6'd42);
      idle(2);
      mul(6'd20, 6'd21);
      mul(6'd22, 6'd23);
      step(1'b0, 1'b0, 6'd0, 6'd0, 1'b1);
      dvd(6'd12, 6'd43);
      idle(20);

      // Flush in the same cycle as a divide issue.
      step(1'b1, 1'b1, 6'd13, 6'd44, 1'b1);
      idle(3);

      // Randomized traffic; divides only issued while the divider is free.
      for (int i = 0; i < 3000; i++) begin
         f = ($urandom_range(0, 99) < 3);
         v = ($urandom_range(0, 99) < 45);
         d = v && !div_pend && ($urandom_range(0, 3) == 0);
         step(v, d, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), f);
      end
      idle(25);

      // Reset mid-divide (counter at 7), then nothing of that divide may come back.
      dvd(6'd33, 6'd50);
      idle(9);
      async_reset();
      idle(30);

      for (int i = 0; i < 500; i++) begin
         v = ($urandom_range(0, 99) < 60);
         d = v && !div_pend && ($urandom_range(0, 1) == 0);
         step(v, d, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'b0);
      end
      idle(25);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
